// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH runtime-programmable clock dividers and tick generators on one fabric clock.
// Define CLKDIV_PHASE_EN to give every channel a programmable start phase (otherwise start = 0).
module clk_div_bank #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 8,
  parameter int DEF_DIV  = 2,
  parameter int LOCK_CYC = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LOCK_W  = $clog2(LOCK_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] HIGH_RST = DIV_W'(DEF_DIV / 2);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);

  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, div_q, high_q;
  logic [NUM_CH-1:0][DIV_W-1:0] cnt_nxt, div_nxt, high_nxt, start_nxt;
  logic [NUM_CH-1:0]            en_q, clk_q, tick_q, apply_ch;
  logic                         pend_q, pend_ok_q;
  logic [CH_W-1:0]              pend_ch_q;
  logic [DIV_W-1:0]             pend_div_q, pend_high_q, acc_div, acc_high;
  logic                         accept, apply_any, discard, lock_event;
  logic [LOCK_W-1:0]            lock_cnt_q, lock_nxt;
  logic                         lock_q;
`ifdef CLKDIV_PHASE_EN
  logic [NUM_CH-1:0][DIV_W-1:0] phase_q, phase_nxt;
  logic [DIV_W-1:0]             pend_phase_q, acc_phase;
`else
  logic                         unused_phase;
  assign unused_phase = ^cfg_phase;
`endif

  assign cfg_ready  = !pend_q && !rst;
  assign accept     = cfg_valid && cfg_ready;
  assign discard    = pend_q && !pend_ok_q;
  assign apply_any  = |apply_ch;
  assign lock_event = accept || apply_any || sync || (ch_en != en_q);
  assign clk_out    = clk_q;
  assign tick       = tick_q;
  assign locked     = lock_q;

  // High and phase are clamped against the already-clamped divide ratio.
  always_comb begin
    acc_div  = (cfg_div < TWO) ? TWO : cfg_div;
    acc_high = (cfg_high == '0) ? ONE : cfg_high;
    if (acc_high >= acc_div) acc_high = acc_div - ONE;
`ifdef CLKDIV_PHASE_EN
    acc_phase = (cfg_phase >= acc_div) ? acc_div - ONE : cfg_phase;
`endif
  end

  // A pending entry lands only at a period boundary (or at once on an idle channel),
  // and the counter always sees the configuration it will run with.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      apply_ch[i] = pend_q && pend_ok_q && (pend_ch_q == CH_W'(i)) &&
                    (!ch_en[i] || (cnt_q[i] == div_q[i] - ONE));
      div_nxt[i]  = apply_ch[i] ? pend_div_q  : div_q[i];
      high_nxt[i] = apply_ch[i] ? pend_high_q : high_q[i];
`ifdef CLKDIV_PHASE_EN
      phase_nxt[i] = apply_ch[i] ? pend_phase_q : phase_q[i];
      start_nxt[i] = phase_nxt[i];
`else
      start_nxt[i] = '0;
`endif
      if (!ch_en[i] || !en_q[i] || sync) cnt_nxt[i] = start_nxt[i];
      else if (cnt_q[i] == div_q[i] - ONE) cnt_nxt[i] = '0;
      else cnt_nxt[i] = cnt_q[i] + ONE;
    end
  end

  always_comb begin
    if (lock_event) lock_nxt = '0;
    else if (lock_cnt_q == LOCK_W'(LOCK_CYC)) lock_nxt = lock_cnt_q;
    else lock_nxt = lock_cnt_q + LOCK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      div_q        <= {NUM_CH{DIV_RST}};
      high_q       <= {NUM_CH{HIGH_RST}};
      en_q         <= '0;
      clk_q        <= '0;
      tick_q       <= '0;
      pend_q       <= 1'b0;
      pend_ok_q    <= 1'b0;
      pend_ch_q    <= '0;
      pend_div_q   <= '0;
      pend_high_q  <= '0;
      lock_cnt_q   <= '0;
      lock_q       <= 1'b0;
`ifdef CLKDIV_PHASE_EN
      phase_q      <= '0;
      pend_phase_q <= '0;
`endif
    end else begin
      cnt_q      <= cnt_nxt;
      div_q      <= div_nxt;
      high_q     <= high_nxt;
      en_q       <= ch_en;
      lock_cnt_q <= lock_nxt;
      lock_q     <= (lock_nxt == LOCK_W'(LOCK_CYC));
      for (int i = 0; i < NUM_CH; i++) begin
        clk_q[i]  <= ch_en[i] && (cnt_nxt[i] < high_nxt[i]);
        tick_q[i] <= ch_en[i] && (cnt_nxt[i] == '0);
      end
`ifdef CLKDIV_PHASE_EN
      phase_q <= phase_nxt;
`endif
      if (accept) begin
        pend_q      <= 1'b1;
        pend_ok_q   <= ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
        pend_ch_q   <= cfg_ch;
        pend_div_q  <= acc_div;
        pend_high_q <= acc_high;
`ifdef CLKDIV_PHASE_EN
        pend_phase_q <= acc_phase;
`endif
      end else if (apply_any || discard) begin
        pend_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed stimulus with a cycle-indexed scoreboard for clk_div_bank.
// Expectations are queued by the stimulus and consumed by an independent negedge monitor.
module tb_clk_div_bank;
  localparam int SIG_CLK  = 0;
  localparam int SIG_TICK = 1;
  localparam int SIG_LOCK = 2;
  localparam int SIG_RDY  = 3;

  typedef struct {
    int         at;
    int         sig;
    logic [3:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_en;
  logic       sync;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [7:0] cfg_high;
  logic [7:0] cfg_phase;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic       locked;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  clk_div_bank dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .clk_out(clk_out), .tick(tick), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", nm, cyc, act, exp_v);
    end
  endtask

  function automatic logic [3:0] actualOf(input int sig);
    case (sig)
      SIG_CLK:  return clk_out;
      SIG_TICK: return tick;
      SIG_LOCK: return {3'b000, locked};
      default:  return {3'b000, cfg_ready};
    endcase
  endfunction

  // Monitor: consumes every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        checkOutput(sb[i].name, actualOf(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic expectOut(input int at, input int sig, input logic [3:0] v, input string nm);
    exp_t e;
    e.at = at;
    e.sig = sig;
    e.val = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic gotoCycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic s, input logic v,
                               input logic [1:0] ch, input logic [7:0] d,
                               input logic [7:0] h, input logic [7:0] p);
    ch_en = en;
    sync = s;
    cfg_valid = v;
    cfg_ch = ch;
    cfg_div = d;
    cfg_high = h;
    cfg_phase = p;
    step();
    sync = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ch_en = 4'hF; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_high = '0; cfg_phase = '0;

    // Reset, then all channels at default divide-by-2.
    expectOut(1, SIG_CLK, 4'h0, "rst_clk");
    expectOut(1, SIG_TICK, 4'h0, "rst_tick");
    expectOut(1, SIG_LOCK, 4'h0, "rst_locked");
    expectOut(3, SIG_RDY, 4'h0, "rst_ready");
    expectOut(5, SIG_CLK, 4'hF, "t1_clk_c5");
    expectOut(5, SIG_TICK, 4'hF, "t1_tick_c5");
    expectOut(5, SIG_RDY, 4'h1, "t1_ready");
    expectOut(6, SIG_CLK, 4'h0, "t1_clk_c6");
    expectOut(6, SIG_TICK, 4'h0, "t1_tick_c6");
    expectOut(7, SIG_CLK, 4'hF, "t1_clk_c7");
    expectOut(20, SIG_LOCK, 4'h0, "t1_lock_c20");
    expectOut(21, SIG_LOCK, 4'h1, "t1_lock_c21");
    gotoCycle(4);
    rst = 1'b0;

    // ch1 div=5 high=2 accepted mid-period.
    gotoCycle(22);
    expectOut(22, SIG_LOCK, 4'h1, "t2_lock_before");
    expectOut(23, SIG_RDY, 4'h0, "t2_ready_c23");
    expectOut(23, SIG_LOCK, 4'h0, "t2_lock_drop");
    expectOut(23, SIG_CLK, 4'hF, "t2_clk_c23");
    expectOut(24, SIG_RDY, 4'h0, "t2_ready_c24");
    expectOut(24, SIG_CLK, 4'h0, "t2_clk_c24");
    expectOut(25, SIG_RDY, 4'h1, "t2_ready_c25");
    expectOut(25, SIG_CLK, 4'hF, "t2_clk_c25");
    expectOut(25, SIG_TICK, 4'hF, "t2_tick_c25");
    expectOut(26, SIG_CLK, 4'b0010, "t2_clk_c26");
    expectOut(26, SIG_TICK, 4'h0, "t2_tick_c26");
    expectOut(27, SIG_CLK, 4'b1101, "t2_clk_c27");
    expectOut(27, SIG_TICK, 4'b1101, "t2_tick_c27");
    expectOut(28, SIG_CLK, 4'h0, "t2_clk_c28");
    expectOut(29, SIG_CLK, 4'b1101, "t2_clk_c29");
    expectOut(30, SIG_CLK, 4'b0010, "t2_clk_c30");
    expectOut(30, SIG_TICK, 4'b0010, "t2_tick_c30");
    expectOut(35, SIG_TICK, 4'hF, "t2_tick_c35");
    expectOut(40, SIG_LOCK, 4'h0, "t2_lock_c40");
    expectOut(41, SIG_LOCK, 4'h1, "t2_lock_c41");
    applyStimulus(4'hF, 1'b0, 1'b1, 2'd1, 8'd5, 8'd2, 8'd0);

    // ch1 div=0 high=9 (clamps to 2/1); valid held with new data while not ready.
    gotoCycle(41);
    expectOut(42, SIG_RDY, 4'h0, "t3_ready_c42");
    expectOut(43, SIG_RDY, 4'h0, "t3_ready_c43");
    expectOut(44, SIG_RDY, 4'h0, "t3_ready_c44");
    expectOut(45, SIG_RDY, 4'h1, "t3_ready_c45");
    expectOut(45, SIG_CLK, 4'hF, "t3_clk_c45");
    expectOut(45, SIG_TICK, 4'hF, "t3_tick_c45");
    expectOut(46, SIG_CLK, 4'h0, "t3_clk_c46");
    expectOut(46, SIG_RDY, 4'h1, "t3_ready_c46");
    expectOut(47, SIG_CLK, 4'hF, "t3_clk_c47");
    expectOut(47, SIG_TICK, 4'hF, "t3_tick_c47");
    expectOut(48, SIG_CLK, 4'h0, "t3_clk_c48");
    expectOut(49, SIG_CLK, 4'hF, "t3_clk_c49");
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0; cfg_high = 8'd9; cfg_phase = 8'd0;
    step();
    cfg_div = 8'd7; cfg_high = 8'd3;
    step();
    step();
    cfg_valid = 1'b0;

    // ch0 div=3, ch2 div=6, then sync.
    gotoCycle(49);
    expectOut(50, SIG_RDY, 4'h0, "t4_ready_c50");
    expectOut(51, SIG_RDY, 4'h1, "t4_ready_c51");
    expectOut(52, SIG_RDY, 4'h0, "t4_ready_c52");
    expectOut(53, SIG_RDY, 4'h1, "t4_ready_c53");
    expectOut(56, SIG_TICK, 4'hF, "t4_tick_sync");
    expectOut(56, SIG_CLK, 4'hF, "t4_clk_c56");
    expectOut(57, SIG_TICK, 4'h0, "t4_tick_c57");
    expectOut(57, SIG_CLK, 4'b0100, "t4_clk_c57");
    expectOut(58, SIG_TICK, 4'b1010, "t4_tick_c58");
    expectOut(58, SIG_CLK, 4'b1110, "t4_clk_c58");
    expectOut(59, SIG_TICK, 4'b0001, "t4_tick_c59");
    expectOut(59, SIG_CLK, 4'b0001, "t4_clk_c59");
    expectOut(62, SIG_TICK, 4'hF, "t4_tick_c62");
    expectOut(65, SIG_TICK, 4'b0001, "t4_tick_c65");
    expectOut(68, SIG_TICK, 4'hF, "t4_tick_c68");
    expectOut(71, SIG_LOCK, 4'h0, "t4_lock_c71");
    expectOut(72, SIG_LOCK, 4'h1, "t4_lock_c72");
    applyStimulus(4'hF, 1'b0, 1'b1, 2'd0, 8'd3, 8'd1, 8'd0);
    gotoCycle(51);
    applyStimulus(4'hF, 1'b0, 1'b1, 2'd2, 8'd6, 8'd3, 8'd0);
    gotoCycle(55);
    applyStimulus(4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);

    // ch0 div=4 phase=0, ch1 div=4 phase=1, then sync.
    gotoCycle(72);
    expectOut(73, SIG_RDY, 4'h0, "t5_ready_c73");
    expectOut(74, SIG_RDY, 4'h1, "t5_ready_c74");
    expectOut(75, SIG_RDY, 4'h0, "t5_ready_c75");
    expectOut(76, SIG_RDY, 4'h1, "t5_ready_c76");
    expectOut(79, SIG_CLK, 4'hF, "t5_clk_c79");
`ifdef CLKDIV_PHASE_EN
    expectOut(79, SIG_TICK, 4'b1101, "t5_tick_c79");
    expectOut(80, SIG_CLK, 4'b0101, "t5_clk_c80");
    expectOut(82, SIG_TICK, 4'b0010, "t5_tick_c82");
    expectOut(83, SIG_TICK, 4'b1001, "t5_tick_c83");
`else
    expectOut(79, SIG_TICK, 4'hF, "t5_tick_c79");
    expectOut(80, SIG_CLK, 4'b0111, "t5_clk_c80");
    expectOut(82, SIG_TICK, 4'b0000, "t5_tick_c82");
    expectOut(83, SIG_TICK, 4'b1011, "t5_tick_c83");
`endif
    applyStimulus(4'hF, 1'b0, 1'b1, 2'd0, 8'd4, 8'd2, 8'd0);
    gotoCycle(74);
    applyStimulus(4'hF, 1'b0, 1'b1, 2'd1, 8'd4, 8'd2, 8'd1);
    gotoCycle(78);
    applyStimulus(4'hF, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);

    // Reset with ch2 config pending and mid-period.
    gotoCycle(84);
    expectOut(85, SIG_RDY, 4'h0, "t6_ready_pending");
    expectOut(88, SIG_CLK, 4'h0, "t6_rst_clk");
    expectOut(88, SIG_TICK, 4'h0, "t6_rst_tick");
    expectOut(88, SIG_LOCK, 4'h0, "t6_rst_lock");
    expectOut(88, SIG_RDY, 4'h0, "t6_rst_ready");
    expectOut(90, SIG_CLK, 4'hF, "t6_clk_c90");
    expectOut(90, SIG_TICK, 4'hF, "t6_tick_c90");
    expectOut(90, SIG_RDY, 4'h1, "t6_ready_c90");
    expectOut(91, SIG_CLK, 4'h0, "t6_clk_c91");
    expectOut(91, SIG_TICK, 4'h0, "t6_tick_c91");
    expectOut(92, SIG_CLK, 4'hF, "t6_clk_c92");
    expectOut(93, SIG_CLK, 4'h0, "t6_clk_c93");
    expectOut(94, SIG_TICK, 4'hF, "t6_tick_c94");
    expectOut(98, SIG_CLK, 4'hF, "t6_clk_c98");
    expectOut(105, SIG_LOCK, 4'h0, "t6_lock_c105");
    expectOut(106, SIG_LOCK, 4'h1, "t6_lock_c106");
    applyStimulus(4'hF, 1'b0, 1'b1, 2'd2, 8'd9, 8'd4, 8'd0);
    gotoCycle(87);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // ch3 disabled, reconfigured to div=3 while idle, then re-enabled.
    gotoCycle(106);
    expectOut(107, SIG_CLK, 4'h0, "t7_clk_c107");
    expectOut(107, SIG_LOCK, 4'h0, "t7_lock_en_change");
    expectOut(108, SIG_CLK, 4'b0111, "t7_clk_c108");
    expectOut(108, SIG_TICK, 4'b0111, "t7_tick_c108");
    expectOut(109, SIG_RDY, 4'h0, "t7_ready_c109");
    expectOut(110, SIG_RDY, 4'h1, "t7_ready_idle_apply");
    expectOut(112, SIG_CLK, 4'hF, "t7_clk_c112");
    expectOut(112, SIG_TICK, 4'hF, "t7_tick_c112");
    expectOut(113, SIG_CLK, 4'h0, "t7_clk_c113");
    expectOut(114, SIG_CLK, 4'b0111, "t7_clk_c114");
    expectOut(115, SIG_CLK, 4'b1000, "t7_clk_c115");
    expectOut(115, SIG_TICK, 4'b1000, "t7_tick_c115");
    expectOut(118, SIG_TICK, 4'hF, "t7_tick_c118");
    applyStimulus(4'b0111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
    gotoCycle(108);
    applyStimulus(4'b0111, 1'b0, 1'b1, 2'd3, 8'd3, 8'd1, 8'd0);
    gotoCycle(111);
    applyStimulus(4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);

    gotoCycle(121);
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: expectation for cycle %0d never checked, expected %b", sb[i].name, sb[i].at, sb[i].val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
